// File: rtl/stopwatch_lap.sv
// Up/down stopwatch (cs/s/min) with short/long key decoding and a lap-time FIFO.
// Single clock domain; the 1 ms and count-tick rates are clock enables.
module stopwatch_lap #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 2000,
    parameter int MIN_MAX     = 99,
    parameter int LAP_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    input  logic       key_lap,
    input  logic       mode_down,
    input  logic [7:0] preset_min,
    input  logic [7:0] preset_sec,
    output logic [7:0] cs,
    output logic [7:0] second,
    output logic [7:0] minute,
    output logic       running,
    output logic       done,
    output logic       wrap,
    output logic       lap_valid,
    input  logic       lap_rd,
    output logic [7:0] lap_min,
    output logic [7:0] lap_sec,
    output logic [7:0] lap_cs,
    output logic       lap_ovf
);
    localparam int MS_DIV   = CLK_HZ / 1000;
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int MS_W     = $clog2(MS_DIV + 1);
    localparam int TICK_W   = $clog2(TICK_DIV + 1);
    localparam int HOLD_W   = $clog2(LONG_MS + 1);
    localparam int AW       = $clog2(LAP_DEPTH);
    localparam int CW       = AW + 1;
    localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_DEB  = HOLD_W'(DEBOUNCE_MS);
    localparam logic [HOLD_W-1:0] HOLD_LONG = HOLD_W'(LONG_MS);
    localparam logic [HOLD_W-1:0] HOLD_PRE  = HOLD_W'(LONG_MS - 1);
    localparam logic [7:0]        MIN_TOP   = 8'(MIN_MAX);
    localparam logic [CW-1:0]     FIFO_FULL = CW'(LAP_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t              state, next_state;
    logic [MS_W-1:0]     ms_cnt;
    logic [TICK_W-1:0]   tick_cnt;
    logic                ms_en, tick_en, at_zero, enter_idle, mode_dn;
    logic [1:0]          key_s1, key_s2, short_evt;
    logic [HOLD_W-1:0]   hold [2];
    logic                long_evt;
    logic [23:0]         lap_mem [LAP_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic                push_req, push, pop;

    assign ms_en = (ms_cnt == MS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ms_cnt <= '0;
        else if (ms_en)  ms_cnt <= '0;
        else             ms_cnt <= ms_cnt + 1'b1;
    end

    // Index 0 is the start/stop key, index 1 the lap key; only key 0 decodes long holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1    <= 2'b11;
            key_s2    <= 2'b11;
            short_evt <= 2'b00;
            long_evt  <= 1'b0;
            for (int i = 0; i < 2; i++) hold[i] <= '0;
        end else begin
            key_s1   <= {key_lap, key};
            key_s2   <= key_s1;
            long_evt <= !key_s2[0] && ms_en && (hold[0] == HOLD_PRE);
            for (int i = 0; i < 2; i++) begin
                short_evt[i] <= key_s2[i] && (hold[i] >= HOLD_DEB) && (hold[i] < HOLD_LONG);
                if (key_s2[i])
                    hold[i] <= '0;
                else if (ms_en && (hold[i] != HOLD_LONG))
                    hold[i] <= hold[i] + 1'b1;
            end
        end
    end

    assign tick_en = (state == RUN) && (tick_cnt == TICK_LAST);
    assign at_zero = mode_dn && (minute == 8'd0) && (second == 8'd0) && (cs <= 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               tick_cnt <= '0;
        else if (state == IDLE)   tick_cnt <= '0;
        else if (state == RUN)    tick_cnt <= tick_en ? '0 : tick_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (short_evt[0]) next_state = RUN;
            RUN: begin
                if (long_evt)                next_state = IDLE;
                else if (tick_en && at_zero) next_state = DONE;
                else if (short_evt[0])       next_state = PAUSE;
            end
            PAUSE: begin
                if (long_evt)          next_state = IDLE;
                else if (short_evt[0]) next_state = RUN;
            end
            DONE:  if (long_evt) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign enter_idle = (next_state == IDLE) && (state != IDLE);
    assign running    = (state == RUN);

    // A long press on the same clock as a tick still wins: the time is cleared on IDLE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {minute, second, cs} <= 24'd0;
            mode_dn <= 1'b0;
            wrap    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == RUN) && (next_state == DONE);
            if (enter_idle) begin
                {minute, second, cs} <= 24'd0;
                wrap <= 1'b0;
            end else if (state == IDLE) begin
                if (short_evt[0]) begin
                    mode_dn <= mode_down;
                    if (mode_down) {minute, second, cs} <= {preset_min, preset_sec, 8'd0};
                end
            end else if (tick_en) begin
                if (!mode_dn) begin
                    if (cs != 8'd99) cs <= cs + 8'd1;
                    else begin
                        cs <= 8'd0;
                        if (second != 8'd59) second <= second + 8'd1;
                        else begin
                            second <= 8'd0;
                            if (minute != MIN_TOP) minute <= minute + 8'd1;
                            else begin
                                minute <= 8'd0;
                                wrap   <= 1'b1;
                            end
                        end
                    end
                end else if (at_zero) begin
                    {minute, second, cs} <= 24'd0;
                end else if (cs != 8'd0) begin
                    cs <= cs - 8'd1;
                end else begin
                    cs <= 8'd99;
                    if (second != 8'd0) second <= second - 8'd1;
                    else begin
                        second <= 8'd59;
                        minute <= minute - 8'd1;
                    end
                end
            end
        end
    end

    assign lap_valid = (count != '0);
    assign pop       = lap_rd && lap_valid;
    assign push_req  = short_evt[1] && ((state == RUN) || (state == PAUSE));
    assign push      = push_req && ((count != FIFO_FULL) || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            lap_ovf <= 1'b0;
        end else if (enter_idle) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            lap_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && !push) lap_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) lap_mem[wr_ptr] <= {minute, second, cs};
    end

    assign {lap_min, lap_sec, lap_cs} = lap_valid ? lap_mem[rd_ptr] : 24'd0;
endmodule
